e_clk_window_gen: RTL

E_CLK_WINDOW_GEN -- requirements
Module: e_clk_window_gen

---
 rtl/e_clk_window_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/e_clk_window_gen.sv
// -----------------------------------------------------------------------------
// e_clk_window_gen
//
// Purpose:
//   Produces per-channel enable windows that follow the 6809 E clock. The E
//   clock is asynchronous to i_clk and passes through a flop synchronizer
//   before edge detection. Each channel opens its window S i_clk cycles after
//   a detected E rise and closes it H i_clk cycles after a detected E fall.
//
// Build option:
//   E_CLK_STALL_WDOG_EN - when defined, a watchdog raises o_stall once
//   STALL_CYCLES i_clk edges pass without an E edge, and closes every window.
//   When undefined, o_stall is tied low and no watchdog logic exists.
//
// Ports:
//   i_clk      fast PLL clock, the only clock
//   i_rst      synchronous active-high reset
//   i_e_clk    asynchronous E clock
//   i_ch_en    per-channel enable; a low bit forces that channel idle
//   i_start    packed per-channel start offsets S, CNT_W bits each
//   i_hold     packed per-channel hold times H, CNT_W bits each
//   o_e_sync   synchronized E (last synchronizer stage)
//   o_e_rise   one-cycle pulse on a detected E rising edge
//   o_e_fall   one-cycle pulse on a detected E falling edge
//   o_win      per-channel enable window, decoded from registered state
//   o_stall    E-clock stall flag (constant 0 without the watchdog)
// -----------------------------------------------------------------------------
module e_clk_window_gen #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 7,
  parameter int SYNC_STAGES  = 2,
  parameter int STALL_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_e_clk,
  input  logic [NUM_CH-1:0]       i_ch_en,
  input  logic [NUM_CH*CNT_W-1:0] i_start,
  input  logic [NUM_CH*CNT_W-1:0] i_hold,
  output logic                    o_e_sync,
  output logic                    o_e_rise,
  output logic                    o_e_fall,
  output logic [NUM_CH-1:0]       o_win,
  output logic                    o_stall
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_HOLD       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q [NUM_CH];
  state_t                 state_d [NUM_CH];
  logic [CNT_W-1:0]       cnt_q   [NUM_CH];
  logic [CNT_W-1:0]       cnt_d   [NUM_CH];
  logic                   force_idle;

  // Synchronizer and edge detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_e_clk};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign o_e_sync = sync_q[SYNC_STAGES-1];
  assign o_e_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_e_fall = ~sync_q[SYNC_STAGES-1] & prev_q;

  // Per-channel window state machines
  always_comb begin
    logic [CNT_W-1:0] start_v;
    logic [CNT_W-1:0] hold_v;
    start_v = '0;
    hold_v  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      start_v    = i_start[k*CNT_W +: CNT_W];
      hold_v     = i_hold[k*CNT_W +: CNT_W];
      unique case (state_q[k])
        ST_IDLE: begin
          if (o_e_rise) begin
            if (start_v == '0) begin
              state_d[k] = ST_ACTIVE;
            end else begin
              state_d[k] = ST_WAIT_START;
              cnt_d[k]   = start_v - 1'b1;
            end
          end
        end
        ST_WAIT_START: begin
          // A fall before the start offset expires cancels the window outright.
          if (o_e_fall) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == '0) begin
            state_d[k] = ST_ACTIVE;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (o_e_fall) begin
            if (hold_v == '0) begin
              state_d[k] = ST_IDLE;
            end else begin
              state_d[k] = ST_HOLD;
              cnt_d[k]   = hold_v - 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // A new rise during hold restarts the window; with S=0 the window
          // stays open without a gap.
          if (o_e_rise) begin
            if (start_v == '0) begin
              state_d[k] = ST_ACTIVE;
              cnt_d[k]   = '0;
            end else begin
              state_d[k] = ST_WAIT_START;
              cnt_d[k]   = start_v - 1'b1;
            end
          end else if (cnt_q[k] == '0) begin
            state_d[k] = ST_IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
      if (!i_ch_en[k] || force_idle) begin
        state_d[k] = ST_IDLE;
        cnt_d[k]   = '0;
      end
    end
  end

  always_comb begin
    o_win = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      o_win[k] = (state_q[k] == ST_ACTIVE) || (state_q[k] == ST_HOLD);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef E_CLK_STALL_WDOG_EN
  // Stall watchdog
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_q, stall_d;

  // The counter saturates at STALL_MAX, so force_idle stays asserted for as
  // long as E is frozen; the next E edge clears everything in its own cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;
    force_idle  = 1'b0;
    if (o_e_rise || o_e_fall) begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else begin
      if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (stall_cnt_d == STALL_MAX) begin
        stall_d    = 1'b1;
        force_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign o_stall = stall_q;
`else
  assign force_idle = 1'b0;
  assign o_stall    = 1'b0;
`endif

endmodule
